// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the segment scan controller.
// The optional blink feature is enabled by defining SEG_SCAN_BLINK_EN.
package seg_scan_pkg;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // {a,b,c,d,e,f,g,dp} patterns for BCD 0..9, dp bit clear
   localparam logic [7:0] SEG_PAT [0:9] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
      8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
   };

   typedef enum logic {BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/bcd2seven_seg.sv
// BCD to 7-segment decoder; codes 10..15 decode to all segments off.
module bcd2seven_seg
   import seg_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (bcd < 4'd10) seg = SEG_PAT[bcd];
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blank gaps, leading-zero
// suppression and frame-aligned loads. SEG_SCAN_BLINK_EN adds per-digit blinking.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 64
`endif
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_en,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   input  logic                    load_valid,
   output logic                    load_ready,
   output logic [7:0]              SEG_DATA,
   output logic [NUM_DIGITS-1:0]   DIGIT_SEL,
   output logic                    frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LEN = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt, cnt_nxt;
   logic [IW-1:0] idx, idx_nxt;
   scan_state_t   state, state_nxt;

   logic [NUM_DIGITS-1:0][3:0] shadow, pend;
   logic [NUM_DIGITS-1:0]      shadow_dp, pend_dp;
   logic                       pend_full;

   logic                  slot_end, frame_end;
   logic [NUM_DIGITS-1:0] supp, sel_oh;
   logic                  lead;
   logic [3:0]            cur_bcd;
   logic [7:0]            dec_seg, seg_val;

   assign slot_end   = (cnt == CNT_LAST);
   assign frame_end  = slot_end && (idx == IDX_LAST);
   assign load_ready = !pend_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         state <= BLANK;
      end else begin
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         state <= state_nxt;
      end
   end

   always_comb begin
      cnt_nxt = cnt + 1'b1;
      idx_nxt = idx;
      if (slot_end) begin
         cnt_nxt = '0;
         idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      state_nxt = (cnt_nxt < BLANK_LEN) ? BLANK : SHOW;
   end

   // Shadow only changes at the frame wrap so a frame never mixes two loads
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow    <= '0;
         shadow_dp <= '0;
         pend      <= '0;
         pend_dp   <= '0;
         pend_full <= 1'b0;
      end else if (frame_end && pend_full) begin
         shadow    <= pend;
         shadow_dp <= pend_dp;
         pend_full <= 1'b0;
      end else if (load_valid && !pend_full) begin
         pend      <= digits_in;
         pend_dp   <= dp_in;
         pend_full <= 1'b1;
      end
   end

   // A zero stays dark only while everything above it is dark; a dp breaks the run
   always_comb begin
      supp = '0;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lead    = lead && (shadow[i] == 4'd0) && !shadow_dp[i];
         supp[i] = lead && lz_en;
      end
   end

   assign cur_bcd = shadow[idx];

   bcd2seven_seg u_dec (
      .bcd (cur_bcd),
      .seg (dec_seg)
   );

`ifdef SEG_SCAN_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0] fcnt;
   logic          blink_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt     <= '0;
         blink_on <= 1'b1;
      end else if (frame_end) begin
         if (fcnt == FW'(BLINK_FRAMES - 1)) begin
            fcnt     <= '0;
            blink_on <= !blink_on;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end
`endif

   always_comb begin
      sel_oh      = '0;
      sel_oh[idx] = 1'b1;
      seg_val     = dec_seg | {7'b0, shadow_dp[idx]};
      if (supp[idx]) seg_val = SEG_BLANK;
`ifdef SEG_SCAN_BLINK_EN
      if (!blink_on && blink_mask[idx]) seg_val = SEG_BLANK;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         SEG_DATA   <= SEG_BLANK;
         DIGIT_SEL  <= '0;
         frame_done <= 1'b0;
      end else begin
         if (state == SHOW) begin
            SEG_DATA  <= seg_val;
            DIGIT_SEL <= sel_oh;
         end else begin
            SEG_DATA  <= SEG_BLANK;
            DIGIT_SEL <= '0;
         end
         frame_done <= (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame/slot arithmetic reference model.
module tb_seg_scan_ctrl;

   localparam int N = 4;
   localparam int R = 8;
   localparam int B = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [4*N-1:0] digits_in;
   logic [N-1:0]   dp_in;
   logic           lz_en;
   logic           load_valid;
   logic           load_ready;
   logic [7:0]     SEG_DATA;
   logic [N-1:0]   DIGIT_SEL;
   logic           frame_done;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask ({N{1'b0}}),
`endif
      .load_valid (load_valid),
      .load_ready (load_ready),
      .SEG_DATA   (SEG_DATA),
      .DIGIT_SEL  (DIGIT_SEL),
      .frame_done (frame_done)
   );

   logic [7:0] pat [0:9] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

   int         n_chk = 0;
   int         n_fail = 0;
   int         t;
   logic [3:0] m_sh [N];
   logic [3:0] m_pd [N];
   logic [N-1:0] m_dp, m_pdp;
   bit         m_full;
   logic [7:0] e_seg;
   logic [N-1:0] e_sel;
   logic       e_fd, e_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, obs, exp);
      end
   endtask

   // Digit ix goes dark when it and every digit above it are 0 with no dp
   function automatic logic [7:0] exp_seg(input int ix);
      logic [7:0] s;
      bit dark = (ix > 0) && lz_en;
      for (int k = ix; k < N; k++)
         if (m_sh[k] != 4'd0 || m_dp[k]) dark = 1'b0;
      if (dark) return 8'h00;
      s = (m_sh[ix] < 4'd10) ? pat[m_sh[ix]] : 8'h00;
      s[0] = m_dp[ix];
      return s;
   endfunction

   task automatic model_edge();
      int c, ix;
      bit acc;
      if (rst) begin
         t = 0; m_full = 0; m_dp = '0;
         for (int k = 0; k < N; k++) m_sh[k] = 4'd0;
         e_seg = 8'h00; e_sel = '0; e_fd = 1'b0;
      end else begin
         c  = t % R;
         ix = (t / R) % N;
         if (c < B) begin
            e_seg = 8'h00; e_sel = '0;
         end else begin
            e_seg = exp_seg(ix);
            e_sel = N'(1) << ix;
         end
         acc = load_valid && !m_full;
         if (c == R - 1 && ix == N - 1 && m_full) begin
            m_sh = m_pd; m_dp = m_pdp; m_full = 0;
         end else if (acc) begin
            for (int k = 0; k < N; k++) m_pd[k] = digits_in[4*k +: 4];
            m_pdp = dp_in; m_full = 1;
         end
         t++;
         e_fd = ((t % R) == R - 1) && (((t / R) % N) == N - 1);
      end
      e_rdy = !m_full;
   endtask

   task automatic tick();
      model_edge();
      @(negedge clk);
      chk("seg_data",   32'(SEG_DATA),   32'(e_seg));
      chk("digit_sel",  32'(DIGIT_SEL),  32'(e_sel));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("load_ready", 32'(load_ready), 32'(e_rdy));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic load(input logic [4*N-1:0] d, input logic [N-1:0] p);
      digits_in = d; dp_in = p; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; digits_in = '0; dp_in = '0; lz_en = 1'b0; load_valid = 1'b0;
      run(2);
      rst = 1'b0;
      load(16'h1234, 4'b0000);
      run(3 * N * R);
      lz_en = 1'b1;
      load(16'h0070, 4'b0000);
      run(70);
      load(16'h0005, 4'b0010);
      run(70);
      lz_en = 1'b0;
      load(16'h000A, 4'b0001);
      run(70);
      // back-to-back: second load held valid across the not-ready window
      load(16'h5678, 4'b0100);
      digits_in = 16'h9012; dp_in = 4'b1000; load_valid = 1'b1;
      run(80);
      load_valid = 1'b0;
      run(40);
      // reset while digit 2 is showing with a load still pending
      load(16'h4321, 4'b0000);
      for (int k = 0; k < 2 * N * R && (t % (N * R)) != 2 * R + 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(40);
      for (int k = 0; k < 3000; k++) begin
         for (int d = 0; d < N; d++)
            digits_in[4*d +: 4] = ($urandom % 2) ? 4'd0 : 4'($urandom % 16);
         for (int d = 0; d < N; d++) dp_in[d] = ($urandom % 8) == 0;
         load_valid = ($urandom % 4) == 0;
         if ($urandom % 50 == 0) lz_en = ~lz_en;
         rst = ($urandom % 500) == 0;
         tick();
      end
      rst = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the fitness-timer display: NUM_DIGITS common-select digits share one 8-bit segment bus and one BCD-to-7-segment decoder.
- Sequences digit selects, inserts an anti-ghosting blank gap between digits, suppresses leading zeros, and merges decimal points.
- Accepts new digit values through a valid/ready handshake and applies them only at frame boundaries, so the display never tears.
- Sits between the timer/counter logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- REFRESH_DIV, 50000, clock cycles per digit slot
- BLANK_CYCLES, 500, blanked cycles at the start of each slot; legal range 1 <= BLANK_CYCLES < REFRESH_DIV

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digits_in  in  4*NUM_DIGITS  BCD digits; nibble 0 is least significant
- dp_in  in  NUM_DIGITS  decimal-point enables, one per digit
- lz_en  in  1  leading-zero suppression enable (sampled live)
- load_valid  in  1  digits_in/dp_in valid
- load_ready  out  1  controller can accept a load
- SEG_DATA  out  8  segments {a,b,c,d,e,f,g,dp}, active-high, bit7=a, bit0=dp
- DIGIT_SEL  out  NUM_DIGITS  one-hot digit enable, active-high
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset:
  - SEG_DATA=0, DIGIT_SEL=0, frame_done=0, load_ready=1.
  - Shadow digits=0, dp=0, pending register empty.
  - Digit index=0, slot counter=0, state=BLANK.
- Slot counter counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV), then wraps to 0 and advances the index. Index wraps NUM_DIGITS-1 -> 0.
- State machine:
  - BLANK while counter < BLANK_CYCLES: DIGIT_SEL=0, SEG_DATA=0.
  - SHOW otherwise: DIGIT_SEL = one-hot(index); SEG_DATA = decode(shadow[index]) with bit0 = shadow_dp[index].
- Outputs are registered and reflect the state and counter of the previous cycle (1-cycle latency).
- Segment patterns for 0..9: FC,60,DA,F2,66,B6,BE,E0,FE,F6 (hex, dp bit clear).
- Invalid BCD (10..15): segments a-g off; dp still honoured.
- Leading-zero suppression (lz_en=1):
  - Digit i shows segments 0 if its value is 0 and every more-significant digit is suppressed.
  - Digit 0 is never suppressed.
  - A digit with dp set is never suppressed and ends suppression for all less-significant digits.
- Handshake:
  - A load is accepted on any cycle with load_valid && load_ready; digits_in and dp_in are captured into the pending register.
  - load_ready=0 while pending is full.
  - Pending is copied to shadow on the cycle the index wraps NUM_DIGITS-1 -> 0; pending empties and load_ready=1 the following cycle.
  - Holding load_valid while load_ready=0 has no effect.
- frame_done: high for exactly the last cycle of digit NUM_DIGITS-1's slot, coincident with the shadow update.
- rst asserted mid-frame: reset state takes effect next edge; the pending load is discarded.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask [NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles a blink phase every BLINK_FRAMES frames, starting in the on phase after reset.
  - In the off phase, masked digits output SEG_DATA=0, dp included; DIGIT_SEL sequencing is unchanged.
- Undefined: no port, no counter, no blinking.

Decomposition:
- Package seg_scan_pkg holds:
  - SEG_BLANK constant
  - digit pattern constant array for 0..9
  - state enum {BLANK, SHOW}
- Decoding uses the existing bcd2seven_seg module as the single sub-module, instantiated once and fed by the index mux.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then load 1,2,3,4 (digit3..0), dp=0:
  - first frame shows 0000 (0xFC) on all digits; load applies at first frame wrap.
  - second frame shows DIGIT_SEL 0001 with SEG_DATA 0x66 (4) on slot counts 2..7, blanks on counts 0..1, then 0x F2/DA/60 for digits 1..3.
  - frame_done fires every 32 cycles.
- lz_en=1, digits 0,0,7,0, dp=0: digit3 and digit2 show 0x00; digit1 shows 0xE0; digit0 shows 0xFC.
- lz_en=1, digits 0,0,0,5, dp[1]=1: digit1 shows 0xFD and is not suppressed; digits 3..2 blank; digit0 shows 0xB6.
- Back-to-back loads:
  - load A accepted; load_ready drops.
  - load B held valid and ignored until the wrap; B accepted on the cycle after ready returns; A displays for one full frame first.
- Digit value 0xA with dp=1: SEG_DATA=0x01.
- rst mid-SHOW of digit 2: next cycle has DIGIT_SEL=0, SEG_DATA=0, load_ready=1; the pending load is lost.
